// File: rtl/sd_cmd_responder.sv
// SD CMD line card-side responder: receives 48-bit host commands, checks
// framing and CRC7, hands index/argument to a local card model and returns
// a 48-bit short response after the NCR gap.
module sd_cmd_responder #(
    parameter int unsigned NCR         = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        sd_clk_i,
    input  logic        sd_cmd_i,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        crc_err_o,
    output logic        frame_err_o,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic [5:0]  rsp_index_i,
    input  logic [31:0] rsp_arg_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        RX,
        CHECK,
        WAIT_RSP,
        GAP,
        TX
    } state_t;

    localparam logic [6:0] NCR_L = 7'(NCR);

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cmd_sync;
    logic                   clk_d;
    logic                   sclk;
    logic                   cmd_s;
    logic                   rise;
    logic                   fall;
    logic [46:0]            rx_sr;
    logic [5:0]             bit_cnt;
    logic [6:0]             crc;
    logic [6:0]             ncr_cnt;
    logic [47:0]            tx_sr;
    logic [5:0]             tx_cnt;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            c = crc7_step(c, d[39-i]);
        end
        return c;
    endfunction

    assign sclk  = clk_sync[SYNC_STAGES-1];
    assign cmd_s = cmd_sync[SYNC_STAGES-1];
    assign rise  = sclk & ~clk_d;
    assign fall  = ~sclk & clk_d;

    // Synchronise bus clock and CMD line through identical chains so the
    // sampled CMD value lines up with the detected clock edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            clk_sync <= '0;
            cmd_sync <= '1;
            clk_d    <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], sd_clk_i};
            cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], sd_cmd_i};
            clk_d    <= sclk;
        end
    end

    // Command receive / response transmit state machine with registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            sd_cmd_o    <= 1'b1;
            sd_cmd_oe_o <= 1'b0;
            cmd_valid_o <= 1'b0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
            cmd_index_o <= '0;
            cmd_arg_o   <= '0;
            rsp_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            crc         <= '0;
            ncr_cnt     <= '0;
            tx_sr       <= '0;
            tx_cnt      <= '0;
        end else begin
            cmd_valid_o <= 1'b0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise && !cmd_s) begin
                        // start bit contributes nothing to a zero-initialised CRC
                        rx_sr   <= '0;
                        bit_cnt <= 6'd1;
                        crc     <= '0;
                        busy_o  <= 1'b1;
                        state   <= RX;
                    end
                end
                RX: begin
                    if (rise) begin
                        rx_sr   <= {rx_sr[45:0], cmd_s};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt < 6'd40) begin
                            crc <= crc7_step(crc, cmd_s);
                        end
                        if (bit_cnt == 6'd47) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    ncr_cnt <= '0;
                    if (!rx_sr[46] || !rx_sr[0]) begin
                        frame_err_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end else if (rx_sr[7:1] != crc) begin
                        crc_err_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cmd_index_o <= rx_sr[45:40];
                        cmd_arg_o   <= rx_sr[39:8];
                        cmd_valid_o <= 1'b1;
                        rsp_ready_o <= 1'b1;
                        state       <= WAIT_RSP;
                    end
                end
                WAIT_RSP, GAP: begin
                    if (rise && !cmd_s) begin
                        // host started a new command: receive it, drop any pending response
                        rx_sr       <= '0;
                        bit_cnt     <= 6'd1;
                        crc         <= '0;
                        rsp_ready_o <= 1'b0;
                        state       <= RX;
                    end else begin
                        if (rise && ncr_cnt != NCR_L) begin
                            ncr_cnt <= ncr_cnt + 7'd1;
                        end
                        if (state == WAIT_RSP) begin
                            if (rsp_valid_i && rsp_ready_o) begin
                                tx_sr <= {2'b00, rsp_index_i, rsp_arg_i,
                                          crc7_40({2'b00, rsp_index_i, rsp_arg_i}), 1'b1};
                                rsp_ready_o <= 1'b0;
                                state       <= GAP;
                            end
                        end else if (fall && ncr_cnt == NCR_L) begin
                            sd_cmd_oe_o <= 1'b1;
                            sd_cmd_o    <= tx_sr[47];
                            tx_sr       <= {tx_sr[46:0], 1'b0};
                            tx_cnt      <= 6'd1;
                            state       <= TX;
                        end
                    end
                end
                TX: begin
                    if (fall) begin
                        if (tx_cnt == 6'd48) begin
                            sd_cmd_oe_o <= 1'b0;
                            sd_cmd_o    <= 1'b1;
                            busy_o      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            sd_cmd_o <= tx_sr[47];
                            tx_sr    <= {tx_sr[46:0], 1'b0};
                            tx_cnt   <= tx_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Self-checking bench for sd_cmd_responder: table-driven host frames plus
// hand-written response and mid-transmit reset sequences, scored via queues.
module tb_sd_cmd_responder;

    logic        clk_i       = 1'b0;
    logic        reset_n_i   = 1'b0;
    logic        sd_clk_i    = 1'b0;
    logic        sd_cmd_i    = 1'b1;
    logic        sd_cmd_o;
    logic        sd_cmd_oe_o;
    logic        cmd_valid_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic        crc_err_o;
    logic        frame_err_o;
    logic        rsp_valid_i = 1'b0;
    logic        rsp_ready_o;
    logic [5:0]  rsp_index_i = '0;
    logic [31:0] rsp_arg_i   = '0;
    logic        busy_o;

    sd_cmd_responder #(.NCR(2), .SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .sd_clk_i    (sd_clk_i),
        .sd_cmd_i    (sd_cmd_i),
        .sd_cmd_o    (sd_cmd_o),
        .sd_cmd_oe_o (sd_cmd_oe_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_index_o (cmd_index_o),
        .cmd_arg_o   (cmd_arg_o),
        .crc_err_o   (crc_err_o),
        .frame_err_o (frame_err_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_index_i (rsp_index_i),
        .rsp_arg_i   (rsp_arg_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always #50 sd_clk_i = ~sd_clk_i;

    typedef struct {
        int          kind;   // 0 = good command, 1 = CRC error, 2 = frame error
        logic [5:0]  idx;
        logic [31:0] arg;
    } ev_t;

    typedef struct {
        logic [47:0] frame;
        int          kind;
        logic [5:0]  idx;
        logic [31:0] arg;
    } vec_t;

    ev_t         ev_q[$];
    logic [47:0] rsp_q[$];
    vec_t        vecs[8];

    int n_checks = 0;
    int n_pass   = 0;
    int rise_cnt = 0;
    int end_rise = 0;
    int cap_cnt  = 0;
    logic [47:0] cap_sr = '0;
    bit rsp_aborted = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'b0001001;
        end
        return c;
    endfunction

    // Score every pulse against the expected-event queue.
    always @(negedge clk_i) begin
        int  kind;
        ev_t e;
        if (reset_n_i && (cmd_valid_o || crc_err_o || frame_err_o)) begin
            kind = cmd_valid_o ? 0 : (crc_err_o ? 1 : 2);
            chk("pulse_onehot", 64'(int'(cmd_valid_o) + int'(crc_err_o) + int'(frame_err_o)), 64'd1);
            if (ev_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
            end else begin
                e = ev_q.pop_front();
                chk("pulse_kind", 64'(kind), 64'(e.kind));
                if (e.kind == 0) begin
                    chk("cmd_index", 64'(cmd_index_o), 64'(e.idx));
                    chk("cmd_arg", 64'(cmd_arg_o), 64'(e.arg));
                end
            end
        end
    end

    // Capture driven response bits at sd_clk rise and score whole frames.
    always @(posedge sd_clk_i) begin
        rise_cnt++;
        if (sd_cmd_oe_o) begin
            if (cap_cnt == 0 && !rsp_aborted) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_oe: got oe=1 expected 0");
                end else begin
                    chk("ncr_gap", 64'((rise_cnt - end_rise - 1) >= 2), 64'd1);
                end
            end
            cap_sr = {cap_sr[46:0], sd_cmd_o};
            cap_cnt++;
        end else if (cap_cnt != 0) begin
            if (!rsp_aborted && rsp_q.size() != 0) begin
                chk("oe_len", 64'(cap_cnt), 64'd48);
                chk("rsp_frame", 64'(cap_sr), 64'(rsp_q.pop_front()));
            end
            cap_cnt = 0;
        end
    end

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk_i);
            sd_cmd_i = f[i];
        end
        end_rise = rise_cnt + 1;
        @(negedge sd_clk_i);
        sd_cmd_i = 1'b1;
        repeat (2) @(negedge sd_clk_i);
    endtask

    task automatic wait_ev_drain(input string name);
        for (int n = 0; n < 300 && ev_q.size() != 0; n++) @(negedge clk_i);
        chk(name, 64'(ev_q.size()), 64'd0);
        ev_q.delete();
    endtask

    task automatic wait_rsp_drain(input string name);
        for (int n = 0; n < 20000 && rsp_q.size() != 0; n++) @(negedge clk_i);
        chk(name, 64'(rsp_q.size()), 64'd0);
        rsp_q.delete();
    endtask

    task automatic respond(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp_frame);
        for (int n = 0; n < 2000 && !rsp_ready_o; n++) @(negedge clk_i);
        chk("rsp_ready_high", 64'(rsp_ready_o), 64'd1);
        rsp_q.push_back(exp_frame);
        rsp_index_i = idx;
        rsp_arg_i   = arg;
        rsp_valid_i = 1'b1;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        chk("rsp_accepted", 64'({rsp_ready_o, busy_o}), 64'b01);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  exp_idx;
        logic [31:0] exp_arg;
        logic [39:0] body;

        body = {2'b01, 6'd17, 32'h12345678};
        vecs[0] = '{48'h400000000095, 0, 6'd0,  32'h0};
        vecs[1] = '{48'h48000001AA87, 0, 6'd8,  32'h000001AA};
        vecs[2] = '{48'h48000001AA85, 1, 6'd0,  32'h0};
        vecs[3] = '{48'h510000000054, 2, 6'd0,  32'h0};
        vecs[4] = '{48'h110000000055, 2, 6'd0,  32'h0};
        vecs[5] = '{{body, crc7(body), 1'b1}, 0, 6'd17, 32'h12345678};
        vecs[6] = '{48'h770000000065, 0, 6'd55, 32'h0};
        vecs[7] = '{48'h400000000095, 0, 6'd0,  32'h0};

        // reset state
        #23;
        chk("reset_ctrl", 64'({sd_cmd_oe_o, sd_cmd_o, cmd_valid_o, crc_err_o, frame_err_o, rsp_ready_o, busy_o}),
            64'b0100000);
        chk("reset_fields", 64'({cmd_index_o, cmd_arg_o}), 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (3) @(negedge sd_clk_i);

        exp_idx = '0;
        exp_arg = '0;
        for (int i = 0; i < 8; i++) begin
            ev_q.push_back('{vecs[i].kind, vecs[i].idx, vecs[i].arg});
            send_frame(vecs[i].frame);
            wait_ev_drain($sformatf("drain_v%0d", i));
            if (vecs[i].kind == 0) begin
                exp_idx = vecs[i].idx;
                exp_arg = vecs[i].arg;
            end
            chk($sformatf("held_index_v%0d", i), 64'(cmd_index_o), 64'(exp_idx));
            chk($sformatf("held_arg_v%0d", i), 64'(cmd_arg_o), 64'(exp_arg));
        end
        chk("table_no_oe", 64'(sd_cmd_oe_o), 64'd0);

        // CMD55 with an R1 response built by the bench model
        body = {2'b00, 6'd55, 32'h00000120};
        ev_q.push_back('{0, 6'd55, 32'h0});
        send_frame(48'h770000000065);
        respond(6'd55, 32'h00000120, {body, crc7(body), 1'b1});
        wait_rsp_drain("rsp_cmd55_done");
        wait_ev_drain("drain_cmd55");
        repeat (2) @(negedge sd_clk_i);
        chk("idle_after_tx", 64'({sd_cmd_oe_o, sd_cmd_o, busy_o}), 64'b010);

        // CMD8 with the R7 echo
        ev_q.push_back('{0, 6'd8, 32'h000001AA});
        send_frame(48'h48000001AA87);
        respond(6'd8, 32'h000001AA, 48'h08000001AA13);
        wait_rsp_drain("rsp_cmd8_done");
        wait_ev_drain("drain_cmd8");

        // reset in the middle of a response
        ev_q.push_back('{0, 6'd8, 32'h000001AA});
        send_frame(48'h48000001AA87);
        respond(6'd8, 32'h000001AA, 48'h08000001AA13);
        for (int n = 0; n < 20000 && cap_cnt < 20; n++) @(negedge clk_i);
        chk("tx_reached_bit20", 64'(cap_cnt >= 20), 64'd1);
        #2;
        rsp_aborted = 1'b1;
        rsp_q.delete();
        reset_n_i = 1'b0;
        #1;
        chk("reset_mid_tx_line", 64'({sd_cmd_oe_o, sd_cmd_o}), 64'b01);
        chk("reset_mid_tx_state", 64'({busy_o, rsp_ready_o, cmd_arg_o}), 64'd0);
        repeat (5) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (3) @(negedge sd_clk_i);

        ev_q.push_back('{0, 6'd0, 32'h0});
        send_frame(48'h400000000095);
        wait_ev_drain("drain_after_reset");
        chk("post_reset_ctrl", 64'({sd_cmd_oe_o, busy_o, rsp_ready_o}), 64'b011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
